// File: rtl/mem_stage.sv
// Memory-access stage: takes one EX/MEM bundle, performs the load/store against a
// variable-latency data memory, and hands a single write-back bundle downstream.
module mem_stage #(
  parameter int AddrWidth        = 64,
  parameter bit ClearDataOnReset = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 pipeline_flush,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [63:0]          result_i,
  input  logic [63:0]          MuxRes_i,
  input  logic [4:0]           rd_i,
  input  logic                 RegWrite_i,
  input  logic                 MemWrite_i,
  input  logic                 MemRead_i,
  input  logic                 MemToReg_i,
  input  logic [2:0]           funct3_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [AddrWidth-1:0] dmem_addr_o,
  output logic [7:0]           dmem_be_o,
  output logic [63:0]          dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [63:0]          dmem_rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [63:0]          wb_data_o,
  output logic [4:0]           rd_o,
  output logic                 RegWrite_o,
  output logic                 misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        squash_q, squash_d;
  logic        misalign_q, misalign_d;
  logic [63:0] result_q, result_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] load_q, load_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memwrite_q, memwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_mem;
  logic        mis_in;

  // Access size is funct3[1:0]: 0=B, 1=H, 2=W, 3=D.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    byte_en = base << off;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [2:0] f3,
                                               input logic [2:0] off);
    logic [63:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{56{lane[7]}}, lane[7:0]};
      3'b001:  load_extract = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_extract = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_extract = {56'd0, lane[7:0]};
      3'b101:  load_extract = {48'd0, lane[15:0]};
      3'b110:  load_extract = {32'd0, lane[31:0]};
      default: load_extract = lane;
    endcase
  endfunction

  assign is_mem = MemRead_i | MemWrite_i;
  assign mis_in = is_mem & is_misaligned(funct3_i[1:0], result_i[2:0]);

  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    misalign_d = misalign_q;
    result_d   = result_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    funct3_d   = funct3_q;
    case (state_q)
      IDLE: begin
        // A flushed bundle is consumed without being captured.
        if (valid_i && !pipeline_flush) begin
          result_d   = result_i;
          wdata_d    = MuxRes_i;
          rd_d       = rd_i;
          regwrite_d = RegWrite_i;
          memwrite_d = MemWrite_i;
          memtoreg_d = MemToReg_i;
          funct3_d   = funct3_i;
          misalign_d = mis_in;
          squash_d   = 1'b0;
          state_d    = (is_mem && !mis_in) ? REQ : DONE;
        end
      end
      REQ: begin
        if (pipeline_flush) state_d = IDLE;
        else if (dmem_gnt_i) state_d = memwrite_q ? DONE : WAIT;
      end
      WAIT: begin
        // A granted load must still drain its response even when squashed.
        if (dmem_rvalid_i) begin
          load_d   = load_extract(dmem_rdata_i, funct3_q, result_q[2:0]);
          state_d  = (squash_q || pipeline_flush) ? IDLE : DONE;
          squash_d = 1'b0;
        end else if (pipeline_flush) begin
          squash_d = 1'b1;
        end
      end
      default: begin
        if (pipeline_flush || ready_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
    end
    if (!reset_ni && ClearDataOnReset) begin
      result_q   <= '0;
      wdata_q    <= '0;
      load_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      funct3_q   <= '0;
    end else begin
      result_q   <= result_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      funct3_q   <= funct3_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign valid_o      = (state_q == DONE);
  assign dmem_req_o   = (state_q == REQ) && !pipeline_flush;
  assign dmem_we_o    = memwrite_q;
  assign dmem_addr_o  = {result_q[AddrWidth-1:3], 3'b000};
  assign dmem_be_o    = byte_en(funct3_q[1:0], result_q[2:0]);
  assign dmem_wdata_o = wdata_q << {result_q[2:0], 3'b000};
  assign wb_data_o    = memtoreg_q ? load_q : result_q;
  assign rd_o         = rd_q;
  assign RegWrite_o   = regwrite_q & ~misalign_q;
  assign misalign_o   = misalign_q & (state_q == DONE);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Consumes one EX/MEM bundle per valid/ready handshake and issues the load or store to a variable-latency data memory.
- For loads, aligns and sign- or zero-extends the returned data.
- Presents a single write-back bundle downstream under valid/ready; non-memory ops pass through as the ALU result.

Parameters:
AddrWidth, 64, data-memory address width; low AddrWidth bits of result_i are used
ClearDataOnReset, 0, when 1, all datapath registers clear to 0 on reset

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_ni  in  1  synchronous, active-low reset
pipeline_flush  in  1  squash the held/in-flight op
valid_i  in  1  EX/MEM bundle valid
ready_o  out  1  stage can accept a bundle
result_i  in  64  ALU result; memory address for loads/stores
MuxRes_i  in  64  store data
rd_i  in  5  destination register
RegWrite_i  in  1  write-back enable
MemWrite_i  in  1  store op
MemRead_i  in  1  load op
MemToReg_i  in  1  write-back selects load data
funct3_i  in  3  access size/sign
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  AddrWidth  doubleword-aligned address (addr[2:0] = 0)
dmem_be_o  out  8  byte enables
dmem_wdata_o  out  64  store data shifted to byte lane
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  64  load doubleword
valid_o  out  1  write-back bundle valid
ready_i  in  1  downstream accepts
wb_data_o  out  64  load data if MemToReg, else result
rd_o  out  5  destination register
RegWrite_o  out  1  write-back enable, forced 0 on misalign
misalign_o  out  1  held op was a misaligned access

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (reset_ni=0): state forced to IDLE. Outputs: valid_o=0, dmem_req_o=0, misalign_o=0, ready_o=1. Data outputs clear only if ClearDataOnReset=1.
- Reset mid-transaction: the pending op is dropped. dmem_rvalid_i arriving in IDLE is ignored.
- IDLE: ready_o=1, valid_o=0. On valid_i & ~pipeline_flush, capture all inputs, then:
  - misaligned → DONE with misalign_o=1, RegWrite_o=0, no memory request;
  - MemRead or MemWrite → REQ;
  - otherwise → DONE.
- ready_o=0 in every state except IDLE.
- Misaligned means: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
- REQ: dmem_req_o=1; addr, we, be and wdata are stable until grant.
  - Store & gnt → DONE.
  - Load & gnt → WAIT.
- WAIT: on dmem_rvalid_i, capture the extracted load data → DONE. dmem_rvalid_i in the same cycle as gnt is not possible; it arrives ≥1 cycle after gnt.
- Byte enables: B = 1 bit, H = 2, W = 4, D = 8 bits, starting at bit addr[2:0]. wdata = MuxRes_i << (8·addr[2:0]).
- Load extraction: byte lane = rdata >> (8·addr[2:0]).
  - funct3 000 LB / 001 LH / 010 LW: sign-extend.
  - 011 LD: full doubleword.
  - 100 LBU / 101 LHU / 110 LWU: zero-extend.
  - 111: treat as LD.
- Store funct3 uses 000–011 only; bit 2 is ignored.
- DONE: valid_o=1 and outputs are stable; on ready_i → IDLE. The next bundle is accepted no earlier than the following IDLE cycle (no bypass).
- wb_data_o = load data when MemToReg, else captured result.
- Latency, valid_i accept cycle N:
  - ALU op: valid_o at N+1.
  - Store with immediate gnt: N+2.
  - Load with immediate gnt and rvalid one cycle later: N+3.
- Flush:
  - IDLE: input not captured but consumed (ready_o=1).
  - REQ: request dropped the same cycle → IDLE.
  - WAIT: set squash; on rvalid → IDLE with no valid_o, since the transaction must complete.
  - DONE: → IDLE, bundle discarded.

Test Plan:
- ALU passthrough: result_i=0x1234, rd=5, RegWrite=1, ready_i=1 → valid_o one cycle after accept, wb_data_o=0x1234, rd_o=5.
- LB sign: addr=0x1003, rdata=0x00000000_80000000 → be=0x08, wb_data_o=0xFFFF_FFFF_FFFF_FF80. Same with LBU → 0x80.
- SW: addr=0x2004, MuxRes=0xDEADBEEF, gnt held 0 for 3 cycles → req stays 1 with wdata=0xDEADBEEF_00000000 and be=0xF0 stable; valid_o one cycle after gnt.
- Misaligned LH at addr=0x11 → no dmem_req_o, valid_o=1, misalign_o=1, RegWrite_o=0.
- Flush in WAIT: load granted, flush next cycle, rvalid two cycles later → valid_o never asserted, ready_o=1 the cycle after rvalid.
- Backpressure and reset: ready_i=0 for 5 cycles in DONE → outputs stable, ready_o=0. reset_ni=0 during WAIT → IDLE next cycle; a later rvalid is ignored.
